ififo_ctrl: RTL and testbench

Sequencing controller for the input-activation FIFO bank that feeds the west edge of the MAC array. On `start` it streams `len` activation vectors from activation SRAM into the row FIFOs. It then drains them into the array under `array_ready` back-pressure, produces an aligned `out_valid` strobe, and pulses `done`. It sits between the top-level core FSM and the input FIFO bank, and owns every control pin of that bank.

---
 rtl/ififo_pkg.sv | 25 ++
 rtl/ififo_ctrl.sv | 102 ++++++++++
 tb/tb_ififo_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/ififo_pkg.sv
// Shared constants and FSM encoding for the input-activation FIFO bank controller.
package ififo_pkg;

    localparam int ROW          = 8;
    localparam int BW           = 4;
    localparam int VEC_W        = ROW * BW;
    localparam int FIFO_DEPTH   = 64;
    localparam int ACT_ADDR_W   = 11;
    localparam int IFIFO_RD_LAT = 2;
    localparam int LEN_W        = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LOAD_WAIT,
        ST_DRAIN,
        ST_FLUSH,
        ST_DONE
    } ififo_ctrl_state_t;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        return (l > LEN_W'(FIFO_DEPTH)) ? LEN_W'(FIFO_DEPTH) : l;
    endfunction

endpackage

// File: rtl/ififo_ctrl.sv
// Streams len vectors SRAM->row FIFOs, then drains them into the MAC array west edge.
// Latency: reads cycles 1..N, fifo_wr 2..N+1, fifo_rd from N+2, out_valid RD_LAT after each fifo_rd.
// Backpressure: array_ready low only holds off new fifo_rd; reads already in flight still emerge.
module ififo_ctrl
    import ififo_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ACT_ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]      len,
    input  logic                  array_ready,
    input  logic                  fifo_full,
    output logic                  sram_cen,
    output logic [ACT_ADDR_W-1:0] sram_addr,
    output logic                  fifo_wr,
    output logic                  fifo_rd,
    output logic                  out_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf_err
);

    ififo_ctrl_state_t state_q, state_d;

    logic [LEN_W-1:0]        len_clamped;
    logic [LEN_W-1:0]        issue_left_q;
    logic [LEN_W-1:0]        rem_q;
    logic [IFIFO_RD_LAT-1:0] vld_sr_q;
    logic                    rd_issue;
    logic                    flush_empty;
    logic                    cen_d, wr_d, busy_d, done_d;

    assign len_clamped = clamp_len(len);

    // Read strobes are decided one cycle ahead so fifo_rd itself is a flop.
    assign rd_issue    = ((state_q == ST_LOAD_WAIT) || (state_q == ST_DRAIN))
                         && array_ready && (rem_q != '0);
    assign flush_empty = !fifo_rd && (vld_sr_q[IFIFO_RD_LAT-2:0] == '0);
    assign out_valid   = vld_sr_q[IFIFO_RD_LAT-1];

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (start) state_d = (len_clamped == '0) ? ST_DONE : ST_LOAD;
            ST_LOAD:      if (issue_left_q == '0) state_d = ST_LOAD_WAIT;
            ST_LOAD_WAIT: state_d = ST_DRAIN;
            ST_DRAIN:     if (rem_q == '0) state_d = ST_FLUSH;
            // Leave once the final out_valid is the only thing still in flight.
            ST_FLUSH:     if (flush_empty) state_d = ST_DONE;
            ST_DONE:      state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cen_d  = (state_d != ST_LOAD);
        wr_d   = !sram_cen;
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sram_cen     <= 1'b1;
            sram_addr    <= '0;
            fifo_wr      <= 1'b0;
            fifo_rd      <= 1'b0;
            vld_sr_q     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            ovf_err      <= 1'b0;
            issue_left_q <= '0;
            rem_q        <= '0;
        end else begin
            sram_cen <= cen_d;
            fifo_wr  <= wr_d;
            fifo_rd  <= rd_issue;
            vld_sr_q <= {vld_sr_q[IFIFO_RD_LAT-2:0], fifo_rd};
            busy     <= busy_d;
            done     <= done_d;
            if (fifo_wr && fifo_full) ovf_err <= 1'b1;

            if ((state_q == ST_IDLE) && start) begin
                sram_addr    <= base_addr;
                issue_left_q <= len_clamped - LEN_W'(1);
                rem_q        <= len_clamped;
            end else if ((state_q == ST_LOAD) && (issue_left_q != '0)) begin
                sram_addr    <= sram_addr + ACT_ADDR_W'(1);
                issue_left_q <= issue_left_q - LEN_W'(1);
            end

            if (rd_issue) rem_q <= rem_q - LEN_W'(1);
        end
    end

endmodule

// File: tb/tb_ififo_ctrl.sv
// Bench for ififo_ctrl: SRAM/FIFO-bank model plus per-job expectations from the job timing rules.
module tb_ififo_ctrl;
    import ififo_pkg::*;

    logic                  clk;
    logic                  reset;
    logic                  start;
    logic [ACT_ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]      len;
    logic                  array_ready;
    logic                  fifo_full;
    logic                  sram_cen;
    logic [ACT_ADDR_W-1:0] sram_addr;
    logic                  fifo_wr;
    logic                  fifo_rd;
    logic                  out_valid;
    logic                  busy;
    logic                  done;
    logic                  ovf_err;

    ififo_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .len        (len),
        .array_ready(array_ready),
        .fifo_full  (fifo_full),
        .sram_cen   (sram_cen),
        .sram_addr  (sram_addr),
        .fifo_wr    (fifo_wr),
        .fifo_rd    (fifo_rd),
        .out_valid  (out_valid),
        .busy       (busy),
        .done       (done),
        .ovf_err    (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    logic [VEC_W-1:0] mem [2048];

    // Observation log for the current job, cycle numbers relative to the start cycle.
    bit mon_en = 1'b0;
    int t0     = 0;
    int busy_cnt;
    int rd_addr_q[$], rd_cyc_q[$], wr_cyc_q[$], frd_cyc_q[$];
    int ov_lat_q[$], ov_dat_q[$], done_q[$];
    int fifo_m[$], infl_dat[$], infl_cyc[$];
    logic [ACT_ADDR_W-1:0] prev_addr = '0;
    bit exp_ovf = 1'b0;

    always @(negedge clk) begin
        int rel;
        rel = cyc - t0;
        if (mon_en) begin
            if (!sram_cen) begin
                rd_addr_q.push_back(int'(sram_addr));
                rd_cyc_q.push_back(rel);
            end
            if (fifo_wr) begin
                wr_cyc_q.push_back(rel);
                fifo_m.push_back(int'(mem[prev_addr]));
            end
            if (fifo_rd) begin
                frd_cyc_q.push_back(rel);
                infl_cyc.push_back(rel);
                infl_dat.push_back((fifo_m.size() > 0) ? fifo_m.pop_front() : 32'hDEAD_BEEF);
            end
            if (out_valid) begin
                if (infl_cyc.size() > 0) begin
                    ov_lat_q.push_back(rel - infl_cyc.pop_front());
                    ov_dat_q.push_back(infl_dat.pop_front());
                end else begin
                    ov_lat_q.push_back(-1);
                    ov_dat_q.push_back(32'hDEAD_BEEF);
                end
            end
            if (done) done_q.push_back(rel);
            if (busy) busy_cnt++;
        end
        prev_addr = sram_addr;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        rd_addr_q.delete(); rd_cyc_q.delete(); wr_cyc_q.delete(); frd_cyc_q.delete();
        ov_lat_q.delete(); ov_dat_q.delete(); done_q.delete();
        fifo_m.delete(); infl_dat.delete(); infl_cyc.delete();
        busy_cnt = 0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_sram_cen"}, int'(sram_cen), 1);
        chk({tag, "_sram_addr"}, int'(sram_addr), 0);
        chk({tag, "_fifo_wr"}, int'(fifo_wr), 0);
        chk({tag, "_fifo_rd"}, int'(fifo_rd), 0);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_ovf_err"}, int'(ovf_err), 0);
    endtask

    function automatic bit ready_for(input int mode, input int rel);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (rel % 2) == 0;
        return 1'($urandom_range(0, 1));
    endfunction

    // mode 0: array_ready held high; 1: toggles 1,0; 2: random.
    task automatic run_job(input logic [ACT_ADDR_W-1:0] b, input logic [LEN_W-1:0] l,
                           input int mode, input bit full);
        int n, exp_done, rel;
        n = (int'(l) > FIFO_DEPTH) ? FIFO_DEPTH : int'(l);
        clear_log();
        @(posedge clk); #1;
        base_addr   = b;
        len         = l;
        start       = 1'b1;
        fifo_full   = full;
        t0          = cyc;
        array_ready = ready_for(mode, 0);
        mon_en      = 1'b1;
        for (int k = 0; k < 800; k++) begin
            @(posedge clk); #1;
            start       = 1'b0;
            rel         = cyc - t0;
            array_ready = ready_for(mode, rel);
            if (done_q.size() > 0 && rel > done_q[0] + 3) break;
        end
        mon_en    = 1'b0;
        fifo_full = 1'b0;
        if (full && n > 0) exp_ovf = 1'b1;

        chk("n_sram_reads", rd_addr_q.size(), n);
        for (int i = 0; i < rd_addr_q.size() && i < n; i++) begin
            chk("sram_addr", rd_addr_q[i], (int'(b) + i) % 2048);
            chk("sram_rd_cycle", rd_cyc_q[i], 1 + i);
        end
        chk("n_fifo_wr", wr_cyc_q.size(), n);
        for (int i = 0; i < wr_cyc_q.size() && i < n; i++)
            chk("fifo_wr_cycle", wr_cyc_q[i], 2 + i);
        chk("n_fifo_rd", frd_cyc_q.size(), n);
        if (frd_cyc_q.size() > 0) chk("fifo_rd_after_load", int'(frd_cyc_q[0] >= n + 2), 1);
        if (mode == 0)
            for (int i = 0; i < frd_cyc_q.size() && i < n; i++)
                chk("fifo_rd_cycle", frd_cyc_q[i], n + 2 + i);
        chk("n_out_valid", ov_lat_q.size(), n);
        for (int i = 0; i < ov_lat_q.size() && i < n; i++) begin
            chk("out_valid_lat", ov_lat_q[i], IFIFO_RD_LAT);
            chk("out_data", ov_dat_q[i], int'(mem[(int'(b) + i) % 2048]));
        end
        if (n == 0)                    exp_done = 1;
        else if (mode == 0)            exp_done = 2 * n + 2 + IFIFO_RD_LAT;
        else if (frd_cyc_q.size() > 0) exp_done = frd_cyc_q[frd_cyc_q.size() - 1] + IFIFO_RD_LAT + 1;
        else                           exp_done = 2 * n + 2 + IFIFO_RD_LAT;
        chk("n_done", done_q.size(), 1);
        if (done_q.size() > 0) chk("done_cycle", done_q[0], exp_done);
        chk("busy_cycles", busy_cnt, exp_done);
        chk("ovf_err", int'(ovf_err), int'(exp_ovf));
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = $urandom;
        reset       = 1'b1;
        start       = 1'b0;
        base_addr   = '0;
        len         = '0;
        array_ready = 1'b0;
        fifo_full   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        run_job(11'h010, 7'd4, 0, 1'b0);
        run_job(11'h123, 7'd64, 1, 1'b0);
        run_job(11'h200, 7'd0, 0, 1'b0);
        run_job(11'h300, 7'd100, 0, 1'b0);
        run_job(11'h7FE, 7'd4, 0, 1'b0);
        for (int j = 0; j < 6; j++)
            run_job(ACT_ADDR_W'($urandom_range(0, 2047)), LEN_W'($urandom_range(0, 127)),
                    int'($urandom_range(0, 2)), 1'b0);
        run_job(11'h040, 7'd2, 0, 1'b1);
        run_job(11'h050, 7'd3, 2, 1'b0);

        // Abort a job mid-drain after three of eight reads.
        clear_log();
        @(posedge clk); #1;
        base_addr   = 11'h0A0;
        len         = 7'd8;
        start       = 1'b1;
        array_ready = 1'b1;
        t0          = cyc;
        mon_en      = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (frd_cyc_q.size() >= 3) break;
        end
        chk("abort_reads_before_reset", frd_cyc_q.size(), 3);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mon_en = 1'b0;
        check_reset_vals("abort");
        chk("abort_no_done", done_q.size(), 0);
        @(negedge clk);
        chk("abort_out_valid_later", int'(out_valid), 0);
        @(posedge clk); #1;
        reset   = 1'b0;
        exp_ovf = 1'b0;
        run_job(11'h0B0, 7'd2, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
